// File: rtl/wb_sdram_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone SDRAM arbiter.
// Holds the arbiter state encoding, the Wishbone CTI/BTE tag constants and a
// helper that sizes the watchdog counter.
package wb_sdram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2,
    ST_TOUT = 2'd3
  } arb_state_t;

  // Cycle type identifiers
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Burst type extensions
  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  // Watchdog counter width: enough bits to hold limit-1, never less than one.
  function automatic int cnt_width(input int limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Stall watchdog for a Wishbone slave port.
//   clk, rst : clock and asynchronous active-high reset
//   count    : a stalled strobe cycle is in progress
//   clear    : restart the count (termination seen or ownership changing)
//   expire   : combinational; high in the stalled cycle whose count equals LIMIT-1
// The counter saturates at LIMIT-1 so it can never wrap.
module wb_watchdog
  import wb_sdram_arbiter_pkg::*;
#(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic count,
  input  logic clear,
  output logic expire
);

  localparam int CW = cnt_width(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt;

  assign expire = count && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// Two-master Wishbone arbiter in front of a single SDRAM controller port.
//   wb_clk_i, wb_rst_i : clock, asynchronous active-high reset
//   m0_*, m1_*         : Wishbone master ports (adr/dat/sel/we/cyc/stb/cti/bte in,
//                        dat/ack/err out)
//   s_*                : forwarded request to the SDRAM controller, dat/ack/err back
//   grant_o            : one-hot current owner (01 = m0, 10 = m1, 00 = none)
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no owner; pick a requester, round-robin when both request
// GNT0    | m0 owns the slave until it drops cyc
// GNT1    | m1 owns the slave until it drops cyc
// TOUT    | owner's access timed out; slave gated off until owner drops cyc
module wb_sdram_arbiter
  import wb_sdram_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic [2:0]      m0_cti_i,
  input  logic [1:0]      m0_bte_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic [2:0]      m1_cti_i,
  input  logic [1:0]      m1_bte_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic [2:0]      s_cti_o,
  output logic [1:0]      s_bte_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      grant_o
);

  // Reset asserts at once but is released only after two clock edges, so the
  // FSM never leaves reset on a partial clock.
  logic [1:0] rst_sync;
  logic       rst_int;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rst_sync <= 2'b11;
    end else begin
      rst_sync <= {rst_sync[0], 1'b0};
    end
  end

  assign rst_int = rst_sync[1];

  arb_state_t state;
  logic       last_m1;   // owner of the most recent grant; also the TOUT owner
  logic [1:0] grant_q;

  logic own0, own1, owned, own_cyc, stall, expire;

  assign own0    = (state == ST_GNT0);
  assign own1    = (state == ST_GNT1);
  assign owned   = own0 || own1;
  assign own_cyc = own1 ? m1_cyc_i : m0_cyc_i;

  assign s_adr_o = own1 ? m1_adr_i : m0_adr_i;
  assign s_dat_o = own1 ? m1_dat_i : m0_dat_i;
  assign s_sel_o = own1 ? m1_sel_i : m0_sel_i;
  assign s_we_o  = own1 ? m1_we_i  : m0_we_i;
  assign s_cti_o = own1 ? m1_cti_i : m0_cti_i;
  assign s_bte_o = own1 ? m1_bte_i : m0_bte_i;
  assign s_cyc_o = owned && own_cyc;
  assign s_stb_o = owned && (own1 ? m1_stb_i : m0_stb_i);

  assign stall = s_cyc_o && s_stb_o && !s_ack_i && !s_err_i;

  // Any non-stalled cycle (idle, termination, owner release) restarts the
  // count; the expiring cycle also clears it since the FSM moves to TOUT.
  wb_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
    .clk    (wb_clk_i),
    .rst    (rst_int),
    .count  (stall),
    .clear  (!stall || expire),
    .expire (expire)
  );

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = own0 && s_ack_i;
  assign m1_ack_o = own1 && s_ack_i;
  assign m0_err_o = own0 && (s_err_i || expire);
  assign m1_err_o = own1 && (s_err_i || expire);
  assign grant_o  = grant_q;

  always_ff @(posedge wb_clk_i or posedge rst_int) begin
    if (rst_int) begin
      state   <= ST_IDLE;
      last_m1 <= 1'b1;
      grant_q <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || last_m1)) begin
            state   <= ST_GNT0;
            last_m1 <= 1'b0;
            grant_q <= 2'b01;
          end else if (m1_cyc_i) begin
            state   <= ST_GNT1;
            last_m1 <= 1'b1;
            grant_q <= 2'b10;
          end
        end
        ST_GNT0, ST_GNT1: begin
          if (!own_cyc) begin
            state   <= ST_IDLE;
            grant_q <= 2'b00;
          end else if (expire) begin
            state   <= ST_TOUT;
            grant_q <= 2'b00;
          end
        end
        ST_TOUT: begin
          if (!(last_m1 ? m1_cyc_i : m0_cyc_i)) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: doc/wb_sdram_arbiter.md
WB_SDRAM_ARBITER -- requirements
Module: wb_sdram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32: Wishbone address width.
REQ-002 SHALL have parameter DW, default 32: Wishbone data width; byte selects are DW/8 bits.
REQ-003 SHALL have parameter TIMEOUT, default 1024: number of stalled strobe cycles before an error is forced; legal range 2..65535.
REQ-004 SHALL have port wb_clk_i, input, 1: sole clock.
REQ-005 SHALL have port wb_rst_i, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have ports m0_adr_i and m1_adr_i, input, AW: master addresses.
REQ-007 SHALL have ports m0_dat_i and m1_dat_i, input, DW: master write data.
REQ-008 SHALL have ports m0_sel_i and m1_sel_i, input, DW/8: master byte selects.
REQ-009 SHALL have ports m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i and m1_stb_i, input, 1 each: master control.
REQ-010 SHALL have ports m0_cti_i and m1_cti_i, input, 3; and m0_bte_i and m1_bte_i, input, 2: burst tags.
REQ-011 SHALL have ports m0_dat_o and m1_dat_o, output, DW: read data.
REQ-012 SHALL have ports m0_ack_o, m0_err_o, m1_ack_o and m1_err_o, output, 1 each: terminations.
REQ-013 SHALL have slave-side ports s_adr_o (AW), s_dat_o (DW), s_sel_o (DW/8), s_we_o, s_cyc_o and s_stb_o (1 each), s_cti_o (3) and s_bte_o (2), all outputs, forwarded to the SDRAM controller.
REQ-014 SHALL have ports s_dat_i (DW), s_ack_i (1) and s_err_i (1), all inputs, returned from the SDRAM controller.
REQ-015 SHALL have port grant_o, output, 2: one-hot current owner; 00 means idle.

Function
REQ-016 SHALL implement FSM states IDLE, GNT0, GNT1 and TOUT, with registered transitions only.
REQ-017 IDLE: SHALL go to GNT0 if only m0_cyc_i is high and to GNT1 if only m1_cyc_i is high; if both are high, SHALL grant the master that did not own the last grant (round-robin pointer).
REQ-018 SHALL update the pointer on each entry to GNT0 or GNT1; the request-to-grant latency SHALL be 1 cycle.
REQ-019 GNTn: the grant SHALL be held while mn_cyc_i is high, covering bursts and locked cycles, with no preemption; mn_cyc_i low SHALL cause a transition to IDLE, giving 1 dead cycle between owners.
REQ-020 While in GNTn, the s_* request outputs SHALL be a combinational copy of master n's inputs; s_dat_i SHALL drive both m0_dat_o and m1_dat_o.
REQ-021 While in GNTn, s_ack_i and s_err_i SHALL route only to master n; the other master's ack and err SHALL be 0.
REQ-022 In IDLE and TOUT, s_cyc_o and s_stb_o SHALL be 0, and all m*_ack_o and m*_err_o SHALL be 0 except as stated in REQ-024.
REQ-023 Watchdog counter: SHALL increment each cycle in GNTn with s_stb_o high and s_ack_i and s_err_i both low; SHALL clear on ack, on err, and on any state change.
REQ-024 When the watchdog count equals TIMEOUT-1 and the condition of REQ-023 still holds, mn_err_o SHALL pulse for exactly that cycle and the FSM SHALL go to TOUT.
REQ-025 TOUT: SHALL stay until mn_cyc_i of the timed-out owner is low, then go to IDLE; a late s_ack_i arriving in TOUT SHALL be dropped.
REQ-026 If s_ack_i and the timeout occur in the same cycle, the ack SHALL win: no err, counter cleared.
REQ-027 Counter width SHALL be clog2(TIMEOUT); the counter SHALL never wrap.

Reset
REQ-028 Assertion of wb_rst_i SHALL take effect immediately, including mid-transfer: state IDLE, pointer favouring m0, counter 0, grant_o 00.
REQ-029 During reset, all s_cyc_o, s_stb_o, m*_ack_o and m*_err_o SHALL be 0; data and address outputs are don't-care.
REQ-030 Deassertion of wb_rst_i SHALL be synchronous to wb_clk_i.

Structure
REQ-031 A shared package SHALL hold the state encoding and the Wishbone CTI/BTE constants (CTI_CLASSIC = 000, CTI_EOB = 111).
REQ-032 The watchdog SHALL be the only sub-module, wb_watchdog (count, clear, expire), so it can be reused by other slave ports.

Verification
REQ-033 Only m0 issues a single read -> grant_o = 01 one cycle later; s_ack_i on slave cycle 3 -> m0_ack_o in the same cycle, m0_dat_o = s_dat_i.
REQ-034 m0 and m1 request continuously after reset -> grants 01, 10, 01, 10 with 1 idle cycle between owners.
REQ-035 m1 runs an 8-beat burst (CTI 010, then 111) while m0 requests -> grant stays 10 for all 8 acks; m0 granted after m1 drops cyc.
REQ-036 TIMEOUT = 16 and the slave never acks m0 -> m0_err_o pulses on stalled cycle 16; s_cyc_o = 0 thereafter; a late ack produces no m0_ack_o.
REQ-037 wb_rst_i asserted mid-burst in GNT1 -> s_cyc_o = 0 and grant_o = 00 without a clock edge; after release, simultaneous requests go to m0 first.
